// File: rtl/vote_pkg.sv
// Shared constants for the voting-machine front end: candidate count,
// FSM state encoding and tally limits.
package vote_pkg;

  localparam int unsigned NUM_CANDIDATES          = 4;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 10;
  localparam int unsigned DEFAULT_COUNT_W         = 8;
  localparam int unsigned SYNC_STAGES             = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_VOTED   = 2'd1;
  localparam logic [1:0] ST_BLOCKED = 2'd2;

  function automatic int unsigned count_max(input int unsigned w);
    return (1 << w) - 1;
  endfunction

  localparam int unsigned COUNT_MAX = count_max(DEFAULT_COUNT_W);

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a debounce counter. The level follows
// the synchronised input only after DEBOUNCE_CYCLES consecutive differing cycles.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic sync,
  output logic level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          meta;
  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      count <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync == level) begin
        count <= '0;
      end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vote_tally.sv
// Voting front end: debounces four candidate buttons, accepts one vote per
// single isolated press in voting mode, and keeps saturating per-candidate tallies.
module vote_tally
  import vote_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned COUNT_W         = DEFAULT_COUNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mode,
  input  logic               button1_raw,
  input  logic               button2_raw,
  input  logic               button3_raw,
  input  logic               button4_raw,
  output logic [COUNT_W-1:0] candidate1_vote,
  output logic [COUNT_W-1:0] candidate2_vote,
  output logic [COUNT_W-1:0] candidate3_vote,
  output logic [COUNT_W-1:0] candidate4_vote,
  output logic               valid_vote_casted,
  output logic               candidate1_button_pressed_level,
  output logic               candidate2_button_pressed_level,
  output logic               candidate3_button_pressed_level,
  output logic               candidate4_button_pressed_level
);

  localparam logic [COUNT_W-1:0] TALLY_MAX = COUNT_W'(count_max(COUNT_W));

  logic [NUM_CANDIDATES-1:0] raw, sync, level;
  logic [COUNT_W-1:0]        tally [NUM_CANDIDATES];
  logic [2:0]                hits;
  logic [1:0]                idx;
  logic [1:0]                state;
  logic [1:0]                fill;
  logic                      armed;

  assign raw = {button4_raw, button3_raw, button2_raw, button1_raw};

  for (genvar i = 0; i < NUM_CANDIDATES; i++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clock (clock),
      .reset (reset),
      .raw   (raw[i]),
      .sync  (sync[i]),
      .level (level[i])
    );
  end

  assign candidate1_button_pressed_level = level[0];
  assign candidate2_button_pressed_level = level[1];
  assign candidate3_button_pressed_level = level[2];
  assign candidate4_button_pressed_level = level[3];

  assign candidate1_vote = tally[0];
  assign candidate2_vote = tally[1];
  assign candidate3_vote = tally[2];
  assign candidate4_vote = tally[3];

  always_comb begin
    hits = '0;
    idx  = '0;
    for (int unsigned i = 0; i < NUM_CANDIDATES; i++) begin
      if (level[i]) begin
        hits = hits + 3'd1;
        idx  = 2'(i);
      end
    end
  end

  // A button already held through reset would otherwise look like a fresh
  // press; votes stay disarmed until every synchronised input is seen low
  // once the synchroniser pipeline has refilled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= ST_IDLE;
      valid_vote_casted <= 1'b0;
      fill              <= '0;
      armed             <= 1'b0;
      for (int unsigned i = 0; i < NUM_CANDIDATES; i++) tally[i] <= '0;
    end else begin
      valid_vote_casted <= 1'b0;
      if (fill != 2'(SYNC_STAGES)) fill <= fill + 2'd1;
      if (fill == 2'(SYNC_STAGES) && sync == '0) armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (hits == 3'd1 && !mode && armed) begin
            if (tally[idx] != TALLY_MAX) tally[idx] <= tally[idx] + 1'b1;
            valid_vote_casted <= 1'b1;
            state             <= ST_VOTED;
          end else if (hits != 3'd0) begin
            state <= ST_BLOCKED;
          end
        end
        ST_VOTED, ST_BLOCKED: begin
          if (level == '0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vote_tally.md
Name: vote_tally

Overview:
- Front-end stage of the voting machine: takes the four raw candidate push-buttons and the mode switch, and produces the vote counts, the vote-accepted strobe and the clean button levels consumed by the mode/display controller.
- Synchronises and debounces each button, then accepts at most one vote per press.
- Rejects simultaneous presses and holds one 8-bit saturating tally per candidate.

Parameters:
- DEBOUNCE_CYCLES, 10: consecutive stable cycles required before a debounced level changes (>=1).
- COUNT_W, 8: width of each tally.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- mode  in  1  0 = voting, 1 = result display (synchronous to clock)
- button1_raw..button4_raw  in  1 each  raw asynchronous candidate buttons, active-high
- candidate1_vote..candidate4_vote  out  COUNT_W each  tally per candidate
- valid_vote_casted  out  1  one-cycle strobe when a vote is accepted
- candidate1_button_pressed_level..candidate4_button_pressed_level  out  1 each  debounced button levels

Behaviour:
- Reset (reset=0, asynchronous): all tallies 0, valid_vote_casted 0, all levels 0, synchroniser and debounce counters cleared, FSM to IDLE. Deassertion is synchronised externally.
- Per button synchroniser and debounce:
  - 2-flop synchroniser, then debounce counter.
  - The counter increments while the synchronised value differs from the current level and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES, the level takes the synchronised value and the counter clears.
  - Raw change sampled at edge k gives a level change at edge k+1+DEBOUNCE_CYCLES if held.
  - Glitches shorter than DEBOUNCE_CYCLES never change the level.
- FSM states: IDLE, VOTED, BLOCKED. It evaluates the registered debounced levels.
  - IDLE, all levels low: stay in IDLE.
  - IDLE, exactly one level high and mode=0: accept the vote and go to VOTED.
    - On that edge the matching tally increments by 1 and valid_vote_casted = 1 for exactly one cycle.
    - The tally saturates at 2^COUNT_W-1. At saturation the strobe still fires and the tally is unchanged.
  - IDLE, two or more levels high, or any level high with mode=1: go to BLOCKED with no vote and no strobe.
  - VOTED and BLOCKED: ignore all new presses. Return to IDLE on the cycle after all four levels are low.
- Timing: one strobe per accepted press. A held button never re-votes. Latency from level rise to strobe/tally update is 1 cycle.
- mode=1 never modifies tallies. Tallies persist across mode changes and are cleared only by reset.
- A mode change while a button is held does not create a vote. A vote accepted in the same cycle that mode goes 1 is not possible, because acceptance requires mode=0 at that edge.
- Reset mid-press: everything clears. After release the button must be seen released-then-pressed, through IDLE, to vote.

Decomposition:
- Package vote_pkg:
  - NUM_CANDIDATES = 4
  - FSM state encoding (IDLE, VOTED, BLOCKED)
  - COUNT_MAX derived from COUNT_W
  - default DEBOUNCE_CYCLES
- Sub-module button_debounce: synchroniser plus debounce counter, parameterised by DEBOUNCE_CYCLES, instantiated four times.
- Top level holds the FSM, one-hot/multiple-press detection, tallies and the strobe.

Test Plan:
- Run all scenarios with DEBOUNCE_CYCLES=4, COUNT_W=8.
- Single clean vote: mode=0, button2 held 20 cycles then released. Expect candidate2_vote 0->1, exactly one valid_vote_casted pulse, button2 level high 5 edges after sampling. Other tallies stay 0.
- Bounce: button1 toggles every 2 cycles for 16 cycles, then holds high. Expect no level change during toggling and exactly one vote after the stable hold. candidate1_vote=1.
- Simultaneous press: button3 and button4 rise on the same cycle, held 10. Expect no strobe and tallies unchanged. After release, a fresh button3 press gives candidate3_vote=1.
- Overlap lockout: button1 pressed, then button2 pressed while button1 is still held, then both released. Expect candidate1_vote=1, candidate2_vote=0, one strobe.
- Mode and saturation: 255 votes on button4, then one more. Expect candidate4_vote stays 255 and the 256th strobe still pulses. With mode=1, pressing button1 gives its level high but no vote. Switching mode to 0 while still held gives no vote until release and re-press.
- Async reset: assert reset=0 mid-press with candidate1_vote=3, no clock edge. Expect all outputs 0 immediately. After release, the held button does not vote until released and pressed again.
